io_device_port: RTL
===================

// Module: io_device_port
// PURPOSE
//  Peripheral end of the basic computer's FGI/FGO I/O handshake: UART 8N1 receiver fills INPR and raises FGI;
//  transmitter serialises OUTR and raises FGO when done. Controller consumes FGI/FGO (SKI/SKO/interrupt R),
//  pulses inp_ack on INP, and pulses out_load on OUT. Sits between controller/AC and the external serial pins.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; integer >= 4, even
//  DW            8   data bits per frame (INPR/OUTR width)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   synchronous, active-high
//  rx_serial    in   1   async serial input, idle high
//  tx_serial    out  1   serial output, idle high
//  inp_ack      in   1   1-cycle pulse: INP executed (AC<-INPR), clears FGI
//  out_load     in   1   1-cycle pulse: OUT executed, latch out_data
//  out_data     in   DW  AC[7:0] at OUT
//  inpr         out  DW  received byte (INPR)
//  FGI          out  1   input flag: inpr holds unread byte
//  FGO          out  1   output flag: transmitter ready for out_load
//  rx_overrun   out  1   sticky: complete frame arrived while FGI=1 (byte dropped)
//  rx_frame_err out  1   1-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  Reset (one clocked cycle with reset=1, also mid-frame): inpr=0, FGI=0, FGO=1, tx_serial=1, rx_overrun=0,
//   rx_frame_err=0, both FSMs IDLE, counters 0, rx synchroniser flops=1. reset overrides every other input.
//  rx_serial passes a 2-flop synchroniser (rx_s); all RX decisions use rx_s.
//  RX FSM: IDLE -> START on rx_s=0; START waits CLKS_PER_BIT/2 cycles, rx_s still 0 -> DATA, else -> IDLE (glitch).
//   DATA samples rx_s every CLKS_PER_BIT cycles (mid-bit), LSB first, DW bits -> STOP.
//   STOP samples after CLKS_PER_BIT: rx_s=1 -> frame valid; rx_s=0 -> rx_frame_err pulse, byte discarded.
//   Both -> IDLE; next start bit is accepted in the cycle after the STOP sample.
//  Valid frame with FGI=0: inpr<=byte, FGI<=1 on the same edge. With FGI=1 and no inp_ack: byte dropped,
//   inpr unchanged, rx_overrun<=1 (cleared only by reset).
//  inp_ack: FGI<=0 next edge; inpr holds its value. inp_ack coincident with a valid frame: ack first,
//   then load -> inpr<=new byte, FGI stays 1, no overrun. inp_ack with FGI=0: no effect.
//  TX FSM: IDLE/START/DATA/STOP. out_load with FGO=1: OUTR<=out_data, FGO<=0, -> START; tx_serial=0 from the
//   next edge. Each bit held exactly CLKS_PER_BIT cycles: start, DW data LSB first, stop (1).
//   FGO<=1 on the edge ending the stop bit; total FGO-low time = (DW+2)*CLKS_PER_BIT cycles.
//  out_load with FGO=0: ignored (OUTR, frame unaffected). out_load in the same cycle FGO rises: ignored.
//  RX and TX fully independent; simultaneous events on both sides allowed.
//  Counters: $clog2(CLKS_PER_BIT)-bit bit timer, $clog2(DW+1)-bit bit index; wrap never reached by design.
//  All outputs registered except none; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared header io_defs.vh: RX/TX state encodings (IDLE=0, START=1, DATA=2, STOP=3), default CLKS_PER_BIT,
//   DW, frame length macro (DW+2). Also used by the controller for FGI/FGO widths.
//  One sub-module: io_bit_timer (clear/enable in, half/full tick out, parameter CLKS_PER_BIT); instantiated
//   once for RX, once for TX. Flag/data registers may reuse my_register.
// TESTING (CLKS_PER_BIT=16, DW=8)
//  1 Reset: hold reset 1 cycle mid-TX frame -> next edge tx_serial=1, FGO=1, FGI=0, inpr=0.
//  2 RX 0xA5 frame on rx_serial -> FGI=1, inpr=0xA5 ~160 cycles after start edge; inp_ack -> FGI=0, inpr=0xA5.
//  3 Second frame 0x3C while FGI=1, no ack -> inpr stays 0xA5, rx_overrun=1; ack coincident with frame -> inpr=0x3C, FGI=1.
//  4 Start glitch of 5 cycles low -> no FGI, FSM back to IDLE; frame 0x81 with stop bit 0 -> rx_frame_err pulse, FGI=0.
//  5 out_load with out_data=0x5A -> FGO=0, tx_serial=0 next cycle, bits 0,1,0,1,1,0,1,0 LSB first then 1,
//    FGO=1 exactly 160 cycles after load; extra out_load mid-frame ignored.
//  6 Loopback tx_serial->rx_serial, send 0x00,0xFF,0x55 back-to-back with ack -> inpr matches each byte.

Source files
------------

// File: rtl/io_device_port_pkg.sv
// Shared definitions for the FGI/FGO serial I/O port: default timing parameters
// and the state encoding used by both the receive and transmit sequencers.
package io_device_port_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DW           = 8;
  localparam int DEF_FRAME_BITS   = DEF_DW + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } port_state_e;

endpackage

// File: rtl/io_device_port_bit_timer.sv
// Per-bit down-counter: tick fires at the half-bit or full-bit terminal count,
// reload on clear or on reaching zero.
module io_device_port_bit_timer
  import io_device_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic half_sel,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TC_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] TC_FULL = '0;

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = RELOAD;
    end else if (enable) begin
      cnt_d = (cnt_q == TC_FULL) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // RELOAD..TC_HALF spans exactly CLKS_PER_BIT/2 enabled cycles after a clear.
  assign tick = enable && (cnt_q == (half_sel ? TC_HALF : TC_FULL));

endmodule

// File: rtl/io_device_port.sv
// Peripheral end of the FGI/FGO handshake: 8N1 receiver loads INPR and raises FGI,
// transmitter serialises OUTR and raises FGO when the stop bit has been sent.
//
//  state    | meaning
//  ST_IDLE  | line idle; RX waits for rx_s=0, TX waits for out_load with FGO=1
//  ST_START | RX: confirm start bit at half-bit; TX: drive start bit
//  ST_DATA  | DW data bits, LSB first, one per full bit period
//  ST_STOP  | RX: sample stop bit; TX: drive stop bit, FGO rises at its end
module io_device_port
  import io_device_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DW           = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_serial,
  output logic          tx_serial,
  input  logic          inp_ack,
  input  logic          out_load,
  input  logic [DW-1:0] out_data,
  output logic [DW-1:0] inpr,
  output logic          FGI,
  output logic          FGO,
  output logic          rx_overrun,
  output logic          rx_frame_err
);

  localparam int IW = $clog2(DW + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DW - 1);

  logic rx_meta_q, rx_s_q;

  port_state_e   rx_state_d, rx_state_q;
  logic [IW-1:0] rx_idx_d, rx_idx_q;
  logic [DW-1:0] rx_shift_d, rx_shift_q;
  logic [DW-1:0] inpr_d, inpr_q;
  logic          fgi_d, fgi_q;
  logic          ovr_d, ovr_q;
  logic          ferr_d, ferr_q;
  logic          rx_clear, rx_en, rx_half, rx_tick, rx_frame_ok;

  port_state_e   tx_state_d, tx_state_q;
  logic [IW-1:0] tx_idx_d, tx_idx_q;
  logic [DW-1:0] outr_d, outr_q;
  logic          tx_d, tx_q;
  logic          fgo_d, fgo_q;
  logic          tx_clear, tx_en, tx_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  io_device_port_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (rx_clear),
    .enable   (rx_en),
    .half_sel (rx_half),
    .tick     (rx_tick)
  );

  io_device_port_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tx_clear),
    .enable   (tx_en),
    .half_sel (1'b0),
    .tick     (tx_tick)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    inpr_d      = inpr_q;
    fgi_d       = fgi_q;
    ovr_d       = ovr_q;
    ferr_d      = 1'b0;
    rx_clear    = 1'b0;
    rx_en       = 1'b1;
    rx_half     = 1'b0;
    rx_frame_ok = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_clear = 1'b1;
        rx_en    = 1'b0;
        if (!rx_s_q) rx_state_d = ST_START;
      end
      ST_START: begin
        rx_half = 1'b1;
        if (rx_tick) begin
          rx_clear   = 1'b1;
          rx_idx_d   = '0;
          rx_state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DW-1:1]};
          if (rx_idx_q == LAST_BIT) rx_state_d = ST_STOP;
          else                      rx_idx_d   = rx_idx_q + IW'(1);
        end
      end
      ST_STOP: begin
        if (rx_tick) begin
          rx_state_d = ST_IDLE;
          rx_idx_d   = '0;
          if (rx_s_q) rx_frame_ok = 1'b1;
          else        ferr_d      = 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase

    // An ack in the same cycle as a completed frame frees INPR for that frame.
    if (rx_frame_ok && (!fgi_q || inp_ack)) begin
      inpr_d = rx_shift_q;
      fgi_d  = 1'b1;
    end else if (rx_frame_ok) begin
      ovr_d = 1'b1;
    end else if (inp_ack) begin
      fgi_d = 1'b0;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    outr_d     = outr_q;
    tx_d       = tx_q;
    fgo_d      = fgo_q;
    tx_clear   = (tx_state_q == ST_IDLE);
    tx_en      = (tx_state_q != ST_IDLE);
    case (tx_state_q)
      ST_IDLE: begin
        if (out_load && fgo_q) begin
          outr_d     = out_data;
          fgo_d      = 1'b0;
          tx_d       = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_tick) begin
          tx_d       = outr_q[0];
          outr_d     = outr_q >> 1;
          tx_idx_d   = '0;
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_tick) begin
          if (tx_idx_q == LAST_BIT) begin
            tx_d       = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_d     = outr_q[0];
            outr_d   = outr_q >> 1;
            tx_idx_d = tx_idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tx_tick) begin
          fgo_d      = 1'b1;
          tx_idx_d   = '0;
          tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= ST_IDLE;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      inpr_q     <= '0;
      fgi_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= ST_IDLE;
      tx_idx_q   <= '0;
      outr_q     <= '0;
      tx_q       <= 1'b1;
      fgo_q      <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      inpr_q     <= inpr_d;
      fgi_q      <= fgi_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      outr_q     <= outr_d;
      tx_q       <= tx_d;
      fgo_q      <= fgo_d;
    end
  end

  assign tx_serial    = tx_q;
  assign inpr         = inpr_q;
  assign FGI          = fgi_q;
  assign FGO          = fgo_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;

endmodule
